// File: rtl/mux_5.sv
// mux_5: two-input WIDTH-bit select for the write-destination register
// address. The unicycle datapath uses it to choose between the rt and rd
// fields.
//
// The selected value is produced combinationally for same-cycle use. A
// registered copy of the selected value and of the select bit is also kept
// for pipelined consumers. A change flag shows when the select differs from
// the value captured at the last edge.
//
// Ports:
//   clk           in   rising-edge clock; used only by the registered copies
//   reset         in   asynchronous, active-high; clears outMuxQ and selQ
//   inputA        in   WIDTH  chosen when controlSignal = 0
//   inputB        in   WIDTH  chosen when controlSignal = 1
//   controlSignal in   1      select bit
//   outMux        out  WIDTH  combinational selected value
//   outMuxQ       out  WIDTH  outMux captured at the last rising edge
//   selQ          out  1      controlSignal captured at the last rising edge
//   selChanged    out  1      controlSignal ^ selQ (combinational)
//
// There is no handshake. Every output is valid at all times. The registered
// outputs update once per rising clk edge while reset is low.

module mux_5 #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             controlSignal,
  output logic [WIDTH-1:0] outMux,
  output logic [WIDTH-1:0] outMuxQ,
  output logic             selQ,
  output logic             selChanged
);

  logic [WIDTH-1:0] out_mux;
  logic [WIDTH-1:0] out_mux_d;
  logic [WIDTH-1:0] out_mux_q;
  logic             sel_d;
  logic             sel_q;

  // Selection logic does not depend on clk or reset. It keeps tracking the
  // inputs while reset is asserted.
  always_comb begin
    out_mux   = inputA;
    out_mux_d = out_mux_q;
    sel_d     = sel_q;
    if (controlSignal) begin
      out_mux = inputB;
    end
    out_mux_d = out_mux;
    sel_d     = controlSignal;
  end

  // Registered copies clear as soon as reset rises, without waiting for a
  // clock edge. The first capture happens on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_mux_q <= '0;
      sel_q     <= 1'b0;
    end else begin
      out_mux_q <= out_mux_d;
      sel_q     <= sel_d;
    end
  end

  assign outMux     = out_mux;
  assign outMuxQ    = out_mux_q;
  assign selQ       = sel_q;
  // Goes high for the rest of the cycle once the select toggles, and stays
  // high until the next edge captures the new select.
  assign selChanged = controlSignal ^ sel_q;

endmodule

// File: tb/tb_mux_5.sv
// Testbench for mux_5. Directed vectors are hand-computed, and a random
// phase is checked against a reference expression plus a one-edge-delayed
// model. Expected responses are queued by the driver and compared by a
// separate monitor.

module tb_mux_5;

  localparam int W = 5;

  typedef struct {
    int             id;
    logic [W-1:0]   mux;
    logic [W-1:0]   muxq;
    logic           selq;
    logic           chg;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic         clk;
  logic         reset;
  logic [W-1:0] input_a;
  logic [W-1:0] input_b;
  logic         control_signal;
  logic [W-1:0] out_mux;
  logic [W-1:0] out_mux_q;
  logic         sel_q;
  logic         sel_changed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_5 #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .inputA        (input_a),
    .inputB        (input_b),
    .controlSignal (control_signal),
    .outMux        (out_mux),
    .outMuxQ       (out_mux_q),
    .selQ          (sel_q),
    .selChanged    (sel_changed)
  );

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   chk_id = 0;

  // Bench-side model of the registered outputs
  logic [W-1:0] m_muxq;
  logic         m_selq;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    input_a        = a;
    input_b        = b;
    control_signal = c;
  endtask

  // Push the expected response for the current inputs and trigger the monitor
  task automatic check();
    exp_t e;
    #1;
    e.id   = chk_id;
    e.mux  = control_signal ? input_b : input_a;
    e.muxq = m_muxq;
    e.selq = m_selq;
    e.chg  = control_signal ^ m_selq;
    chk_id++;
    exp_q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  // Advance through one rising edge, update the model, and return at the
  // following falling edge
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      m_muxq = control_signal ? input_b : input_a;
      m_selq = control_signal;
    end
    @(negedge clk);
  endtask

  task automatic set_reset(input logic r);
    reset = r;
    if (r) begin
      m_muxq = '0;
      m_selq = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(chk_ev) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (out_mux !== e.mux) begin
        n_bad++;
        $display("FAIL chk%0d outMux got %b exp %b", e.id, out_mux, e.mux);
      end
      n_cmp++;
      if (out_mux_q !== e.muxq) begin
        n_bad++;
        $display("FAIL chk%0d outMuxQ got %b exp %b", e.id, out_mux_q, e.muxq);
      end
      n_cmp++;
      if (sel_q !== e.selq) begin
        n_bad++;
        $display("FAIL chk%0d selQ got %b exp %b", e.id, sel_q, e.selq);
      end
      n_cmp++;
      if (sel_changed !== e.chg) begin
        n_bad++;
        $display("FAIL chk%0d selChanged got %b exp %b", e.id, sel_changed, e.chg);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    m_muxq = '0;
    m_selq = 1'b0;
    drive(5'b00000, 5'b00001, 1'b0);
    set_reset(1'b1);
    @(negedge clk);

    // Reset state; the combinational path keeps working during reset
    check();
    drive(5'b00000, 5'b00001, 1'b1);
    check();                               // outMux=1, selChanged=1
    tick();
    check();                               // still held at zero
    drive(5'b00000, 5'b00001, 1'b0);
    set_reset(1'b0);
    check();

    // Select basic: 0 then 1, then capture
    tick();
    check();                               // outMuxQ=0, selQ=0
    drive(5'b00000, 5'b00001, 1'b1);
    check();                               // outMux=1, selChanged=1
    tick();
    check();                               // outMuxQ=1, selQ=1, selChanged=0

    // Alternating patterns with select toggling every cycle
    drive(5'b10101, 5'b01010, 1'b0);
    check();
    tick();
    drive(5'b10101, 5'b01010, 1'b1);
    check();
    tick();
    drive(5'b10101, 5'b01010, 1'b0);
    check();
    tick();
    check();

    // Extremes: no bit leakage between the two inputs
    drive(5'b11111, 5'b00000, 1'b1);
    check();
    tick();
    check();
    drive(5'b11111, 5'b00000, 1'b0);
    check();
    tick();
    check();                               // outMuxQ=11111

    // Asynchronous reset asserted between edges while outMuxQ=11111
    #2;
    set_reset(1'b1);
    check();                               // cleared immediately
    drive(5'b01100, 5'b10011, 1'b1);
    check();                               // outMux keeps tracking
    tick();
    check();                               // held at zero through an edge
    set_reset(1'b0);
    check();
    tick();
    check();                               // capture resumes: 10011, selQ=1

    // Random data and select
    for (int i = 0; i < 1000; i++) begin
      drive(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)));
      check();
      tick();
    end
    check();

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending got %0d exp 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
